// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider family.
// Holds the run-state encoding, default sizing and the low-phase length rule.
package clk_div_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int CNT_W_DEF   = 16;
    localparam int DIV_RST_DEF = 100;

    // Low phase is the larger half, so odd ratios spend the extra cycle low.
    function automatic logic [31:0] low_len(input logic [31:0] n);
        return (n >> 1) + {31'd0, n[0]};
    endfunction

endpackage

// File: rtl/freq_div_prog.sv
// Runtime-programmable integer clock divider with balanced duty cycle.
// The ratio is only re-sampled at period boundaries so clk_div never glitches.
module freq_div_prog
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DIV_RST = DIV_RST_DEF
) (
    input  logic             clk_ref,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    output logic             clk_div,
    output logic             rise_stb,
    output logic             wrap_stb,
    output logic             running
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] n_q;
    logic             clk_div_q;
    logic             rise_stb_q;
    logic             wrap_stb_q;
    logic             running_q;

    logic [CNT_W-1:0] n_lat_d;
    logic [CNT_W-1:0] low_len_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             is_wrap_s;

    // Ratio candidate, low-phase length and wrap detection for the current period.
    always_comb begin
        n_lat_d   = (div_val < CNT_W'(2)) ? CNT_W'(DIV_RST) : div_val;
        low_len_s = CNT_W'(low_len(32'(n_q)));
        cnt_inc_s = cnt_q + CNT_W'(1);
        is_wrap_s = (cnt_q == (n_q - CNT_W'(1)));
    end

    // Divider state machine; every output is a flop so downstream sees clean edges.
    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            n_q        <= CNT_W'(DIV_RST);
            clk_div_q  <= 1'b0;
            rise_stb_q <= 1'b0;
            wrap_stb_q <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            rise_stb_q <= 1'b0;
            wrap_stb_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    clk_div_q <= 1'b0;
                    cnt_q     <= '0;
                    if (en) begin
                        n_q       <= n_lat_d;
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end else begin
                        running_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (is_wrap_s) begin
                        cnt_q      <= '0;
                        clk_div_q  <= 1'b0;
                        wrap_stb_q <= 1'b1;
                        if (en) begin
                            n_q <= n_lat_d;
                        end else begin
                            state_q   <= IDLE;
                            running_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_inc_s;
                        if (cnt_inc_s == low_len_s) begin
                            clk_div_q  <= 1'b1;
                            rise_stb_q <= 1'b1;
                        end else begin
                            clk_div_q  <= clk_div_q;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    clk_div_q <= 1'b0;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign clk_div  = clk_div_q;
    assign rise_stb = rise_stb_q;
    assign wrap_stb = wrap_stb_q;
    assign running  = running_q;

endmodule

// File: tb/tb_freq_div_prog.sv
// Self-checking bench for freq_div_prog: directed scenarios plus random en/div_val
// traffic, all checked cycle by cycle against a position-in-period reference model.
module tb_freq_div_prog;

    localparam int W  = 8;
    localparam int DR = 100;

    logic         clk_ref = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] div_val;
    logic         clk_div;
    logic         rise_stb;
    logic         wrap_stb;
    logic         running;

    always #5 clk_ref = ~clk_ref;

    freq_div_prog #(.CNT_W(W), .DIV_RST(DR)) dut (
        .clk_ref  (clk_ref),
        .rst      (rst),
        .en       (en),
        .div_val  (div_val),
        .clk_div  (clk_div),
        .rise_stb (rise_stb),
        .wrap_stb (wrap_stb),
        .running  (running)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: whether a period is in progress, its ratio, and the position in it.
    bit m_run;
    int m_n;
    int m_pos;
    bit m_wrap;

    function automatic int eff_ratio(input int d);
        return (d < 2) ? DR : d;
    endfunction

    always @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            m_run = 1'b0; m_n = DR; m_pos = 0; m_wrap = 1'b0;
        end else begin
            m_wrap = 1'b0;
            if (!m_run) begin
                if (en) begin
                    m_run = 1'b1; m_n = eff_ratio(int'(div_val)); m_pos = 0;
                end
            end else if (m_pos == m_n - 1) begin
                m_wrap = 1'b1;
                m_pos  = 0;
                if (en) m_n = eff_ratio(int'(div_val));
                else    m_run = 1'b0;
            end else begin
                m_pos++;
            end
        end
    end

    task automatic check_all();
        int low;
        low = (m_n + 1) / 2;
        check_eq("clk_div",  32'(clk_div),  32'(m_run && (m_pos >= low)));
        check_eq("rise_stb", 32'(rise_stb), 32'(m_run && (m_pos == low)));
        check_eq("wrap_stb", 32'(wrap_stb), 32'(m_wrap));
        check_eq("running",  32'(running),  32'(m_run));
    endtask

    task automatic tick(input bit e, input int d);
        @(negedge clk_ref);
        en      = e;
        div_val = W'(d);
        @(posedge clk_ref);
        #1;
        check_all();
    endtask

    task automatic to_idle();
        int guard = 0;
        while (running && guard < 600) begin
            tick(1'b0, 5);
            guard++;
        end
        check_eq("drain_to_idle", 32'(running), 32'd0);
    endtask

    // Edges counted from the en sample (inclusive) to the first observed high clk_div.
    task automatic measure_lat(input int d, input int exp_lat);
        int cnt = 0;
        do begin
            tick(1'b1, d);
            cnt++;
        end while (!clk_div && cnt < 400);
        check_eq("latency", 32'(cnt), 32'(exp_lat));
    endtask

    // From IDLE, holding en for periods*N edges yields exactly that many full periods.
    task automatic run_periods(input int d, input int periods);
        int rises = 0, wraps = 0, highs = 0, guard = 0, nn;
        nn = eff_ratio(d);
        for (int i = 0; i < periods * nn; i++) begin
            tick(1'b1, d);
            rises += int'(rise_stb); wraps += int'(wrap_stb); highs += int'(clk_div);
        end
        do begin
            tick(1'b0, d);
            rises += int'(rise_stb); wraps += int'(wrap_stb); highs += int'(clk_div);
            guard++;
        end while (running && guard < 600);
        check_eq("rise_count", 32'(rises), 32'(periods));
        check_eq("wrap_count", 32'(wraps), 32'(periods));
        check_eq("high_cycles", 32'(highs), 32'(periods * (nn - (nn + 1) / 2)));
        check_eq("idle_after", 32'(running), 32'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; div_val = '0;
        #12;
        check_eq("rst_clk_div", 32'(clk_div), 32'd0);
        check_eq("rst_rise", 32'(rise_stb), 32'd0);
        check_eq("rst_wrap", 32'(wrap_stb), 32'd0);
        check_eq("rst_running", 32'(running), 32'd0);
        @(negedge clk_ref);
        rst = 1'b0;

        // N=100 start-up latency and steady running.
        measure_lat(100, 51);
        for (int i = 0; i < 250; i++) tick(1'b1, 100);
        to_idle();

        run_periods(3, 30);
        run_periods(2, 30);
        run_periods(0, 2);
        run_periods(1, 2);
        run_periods(255, 1);

        // Ratio change 10 -> 4 mid-period takes effect at the next wrap only.
        for (int i = 0; i < 4; i++) tick(1'b1, 10);
        begin
            int highs = 0;
            for (int i = 0; i < 6; i++) begin tick(1'b1, 4); highs += int'(clk_div); end
            check_eq("old_ratio_high", 32'(highs), 32'd5);
        end
        for (int i = 0; i < 12; i++) tick(1'b1, 4);
        to_idle();

        // Drop en during the high phase at N=8.
        begin
            int hi = 0, guard = 0;
            do begin tick(1'b1, 8); guard++; end while (!clk_div && guard < 20);
            hi = int'(clk_div);
            guard = 0;
            while (running && guard < 20) begin
                tick(1'b0, 8); hi += int'(clk_div); guard++;
            end
            check_eq("disable_high_len", 32'(hi), 32'd4);
            for (int i = 0; i < 5; i++) tick(1'b0, 8);
            check_eq("disable_stays_low", 32'(clk_div), 32'd0);
        end

        // Random traffic on en and div_val.
        for (int i = 0; i < 1500; i++) begin
            int d;
            d = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
            tick($urandom_range(0, 9) != 0, d);
        end
        to_idle();

        // Asynchronous reset during the high phase at N=6.
        begin
            int guard = 0;
            do begin tick(1'b1, 6); guard++; end while (!clk_div && guard < 20);
            check_eq("pre_rst_high", 32'(clk_div), 32'd1);
            #2;
            rst = 1'b1; en = 1'b0;
            #1;
            check_eq("async_clk_div", 32'(clk_div), 32'd0);
            check_eq("async_rise", 32'(rise_stb), 32'd0);
            check_eq("async_wrap", 32'(wrap_stb), 32'd0);
            check_eq("async_running", 32'(running), 32'd0);
            @(negedge clk_ref);
            rst = 1'b0;
            measure_lat(6, 4);
            to_idle();
            run_periods(6, 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
